// File: rtl/bcd_score_pkg.sv
// Shared types and elaboration-time helpers for the BCD score bank.
// Contents:
//   bcd_digit_t  - one packed BCD digit
//   BCD_NINE     - digit value 9, the saturation value of a digit
//   BCD_ZERO     - digit value 0, the floor value of a digit
//   bin_to_bcd   - converts a binary constant to up to four packed BCD digits
//   field_offset - bit offset of a channel's field inside the packed score bus
package bcd_score_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_NINE = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;

  // Used at elaboration to turn the binary winning score into the same
  // packed BCD form the counters hold, so matching is a plain equality.
  function automatic logic [15:0] bin_to_bcd(input int unsigned value);
    int unsigned rest;
    logic [15:0] result;
    rest   = value;
    result = '0;
    for (int d = 0; d < 4; d++) begin
      result[d*4 +: 4] = 4'(rest % 10);
      rest = rest / 10;
    end
    return result;
  endfunction

  function automatic int field_offset(input int channel, input int digits);
    return channel * digits * 4;
  endfunction

endpackage

// File: rtl/bcd_updown_counter.sv
// One channel of the score bank: a DIGITS-wide BCD up/down counter that
// saturates at all-9s and floors at zero.
// Ports:
//   clk2       - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   up, dn     - count events for this edge; both together cancel
//   hold       - freezes the count (game over)
//   clr        - synchronous clear, wins over everything else
//   value      - registered packed BCD score, digit 0 in the LSBs
//   sat        - registered, high while value is all-9s
//   next_value - value that will be loaded at the coming edge
module bcd_updown_counter
  import bcd_score_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                  clk2,
  input  logic                  rst_n,
  input  logic                  up,
  input  logic                  dn,
  input  logic                  hold,
  input  logic                  clr,
  output logic [DIGITS*4-1:0]   value,
  output logic                  sat,
  output logic [DIGITS*4-1:0]   next_value
);

  localparam int VAL_W = DIGITS * 4;
  localparam logic [VAL_W-1:0] ALL_NINES = {DIGITS{BCD_NINE}};

  logic [VAL_W-1:0] inc_val;
  logic [VAL_W-1:0] dec_val;
  logic             all_nine;
  logic             all_zero;
  logic             carry;
  logic             borrow;
  bcd_digit_t       digit;

  // Ripple carry/borrow chain: each digit only moves while the carry
  // (or borrow) from the digits below is still pending.
  always_comb begin
    inc_val  = value;
    dec_val  = value;
    carry    = 1'b1;
    borrow   = 1'b1;
    all_nine = 1'b1;
    all_zero = 1'b1;
    digit    = BCD_ZERO;
    for (int d = 0; d < DIGITS; d++) begin
      digit = value[d*4 +: 4];
      if (digit != BCD_NINE) all_nine = 1'b0;
      if (digit != BCD_ZERO) all_zero = 1'b0;
      if (carry) begin
        if (digit == BCD_NINE) begin
          inc_val[d*4 +: 4] = BCD_ZERO;
        end else begin
          inc_val[d*4 +: 4] = digit + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (digit == BCD_ZERO) begin
          dec_val[d*4 +: 4] = BCD_NINE;
        end else begin
          dec_val[d*4 +: 4] = digit - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  // Saturation and floor are checked on the current value so the
  // wrapped results of the chain are never selected at the limits.
  always_comb begin
    next_value = value;
    if (!hold) begin
      if (up && !dn && !all_nine) begin
        next_value = inc_val;
      end else if (dn && !up && !all_zero) begin
        next_value = dec_val;
      end
    end
  end

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
      sat   <= 1'b0;
    end else if (clr) begin
      value <= '0;
      sat   <= 1'b0;
    end else begin
      value <= next_value;
      sat   <= (next_value == ALL_NINES);
    end
  end

endmodule

// File: rtl/bcd_score_bank.sv
// Multi-channel BCD score bank for the Bouncer game. Each channel is an
// independent up/down BCD counter; a sticky game-over detector freezes all
// channels once any of them reaches the winning score.
// Ports:
//   clk2      - system clock, rising edge
//   rst_n     - asynchronous active-low reset
//   inc, dec  - per-channel count requests (edge or level, see EDGE_MODE)
//   clear     - synchronous clear of scores, flags and edge history
//   score     - packed BCD scores, channel i at [i*DIGITS*4 +: DIGITS*4]
//   sat       - per-channel all-9s flag
//   game_over - winning score reached, counting frozen
//   winner    - lowest channel index that reached the winning score
//   tie       - more than one channel reached it on the same edge
module bcd_score_bank
  import bcd_score_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int DIGITS    = 2,
  parameter int EDGE_MODE = 1,
  parameter int WIN_SCORE = 0,
  parameter int WIDX_W    = 3
) (
  input  logic                         clk2,
  input  logic                         rst_n,
  input  logic [CHANNELS-1:0]          inc,
  input  logic [CHANNELS-1:0]          dec,
  input  logic                         clear,
  output logic [CHANNELS*DIGITS*4-1:0] score,
  output logic [CHANNELS-1:0]          sat,
  output logic                         game_over,
  output logic [WIDX_W-1:0]            winner,
  output logic                         tie
);

  localparam int VAL_W = DIGITS * 4;
  localparam logic [15:0]      WIN_BCD_FULL = bin_to_bcd(WIN_SCORE);
  localparam logic [VAL_W-1:0] WIN_BCD      = WIN_BCD_FULL[VAL_W-1:0];
  localparam logic             WIN_ENABLED  = (WIN_SCORE != 0);
  localparam logic             EDGE_ENABLED = (EDGE_MODE != 0);

  logic [CHANNELS-1:0] inc_q;
  logic [CHANNELS-1:0] dec_q;
  logic [CHANNELS-1:0] up;
  logic [CHANNELS-1:0] dn;
  logic [CHANNELS-1:0] match;
  logic [VAL_W-1:0]    value      [CHANNELS];
  logic [VAL_W-1:0]    next_value [CHANNELS];
  logic                any_match;
  logic                multi_match;
  logic [WIDX_W-1:0]   first_idx;

  // Edge history follows the inputs on every edge, including clear and
  // game over, so an input held high across either never looks like a
  // fresh press afterwards.
  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      inc_q <= '0;
      dec_q <= '0;
    end else begin
      inc_q <= inc;
      dec_q <= dec;
    end
  end

  // In level mode the history is masked off and every high cycle counts.
  assign up = inc & ~(EDGE_ENABLED ? inc_q : '0);
  assign dn = dec & ~(EDGE_ENABLED ? dec_q : '0);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    bcd_updown_counter #(
      .DIGITS(DIGITS)
    ) u_counter (
      .clk2      (clk2),
      .rst_n     (rst_n),
      .up        (up[i]),
      .dn        (dn[i]),
      .hold      (game_over),
      .clr       (clear),
      .value     (value[i]),
      .sat       (sat[i]),
      .next_value(next_value[i])
    );

    assign score[field_offset(i, DIGITS) +: VAL_W] = value[i];

    // Once frozen the winning channel still equals WIN_BCD, so matches
    // are masked to keep winner/tie pinned to the edge that ended the game.
    assign match[i] = WIN_ENABLED && !game_over && (next_value[i] == WIN_BCD);
  end

  // Priority encoder: the first hit in index order is the winner, any
  // further hit on the same edge marks a tie.
  always_comb begin
    any_match   = 1'b0;
    multi_match = 1'b0;
    first_idx   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (match[i]) begin
        if (any_match) begin
          multi_match = 1'b1;
        end else begin
          first_idx = WIDX_W'(i);
        end
        any_match = 1'b1;
      end
    end
  end

  // Game-over flag is sticky until clear or reset.
  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      game_over <= 1'b0;
      winner    <= '0;
      tie       <= 1'b0;
    end else if (clear) begin
      game_over <= 1'b0;
      winner    <= '0;
      tie       <= 1'b0;
    end else if (any_match) begin
      game_over <= 1'b1;
      winner    <= first_idx;
      tie       <= multi_match;
    end
  end

endmodule

// File: tb/tb_bcd_score_bank.sv
// Testbench for bcd_score_bank. Three instances share one stimulus bus:
//   dut 0: edge mode, win detection off
//   dut 1: level mode, winning score 15
//   dut 2: edge mode, winning score 15
// Each instance is tracked by an integer score model built from the
// game rules; directed steps cover the corner cases, then random traffic.
module tb_bcd_score_bank;

  localparam int EM [3] = '{1, 0, 1};
  localparam int WS [3] = '{0, 15, 15};

  logic        clk2;
  logic        rst_n;
  logic [1:0]  inc;
  logic [1:0]  dec;
  logic        clear;

  logic [15:0] score_a, score_b, score_c;
  logic [1:0]  sat_a, sat_b, sat_c;
  logic        go_a, go_b, go_c;
  logic [2:0]  win_a, win_b, win_c;
  logic        tie_a, tie_b, tie_c;

  int tests_run;
  int tests_failed;

  int       m_score [3][2];
  bit       m_go    [3];
  int       m_win   [3];
  bit       m_tie   [3];
  bit [1:0] m_prev_inc;
  bit [1:0] m_prev_dec;

  bcd_score_bank #(.CHANNELS(2), .DIGITS(2), .EDGE_MODE(EM[0]), .WIN_SCORE(WS[0]), .WIDX_W(3)) dut_a (
    .clk2(clk2), .rst_n(rst_n), .inc(inc), .dec(dec), .clear(clear),
    .score(score_a), .sat(sat_a), .game_over(go_a), .winner(win_a), .tie(tie_a));

  bcd_score_bank #(.CHANNELS(2), .DIGITS(2), .EDGE_MODE(EM[1]), .WIN_SCORE(WS[1]), .WIDX_W(3)) dut_b (
    .clk2(clk2), .rst_n(rst_n), .inc(inc), .dec(dec), .clear(clear),
    .score(score_b), .sat(sat_b), .game_over(go_b), .winner(win_b), .tie(tie_b));

  bcd_score_bank #(.CHANNELS(2), .DIGITS(2), .EDGE_MODE(EM[2]), .WIN_SCORE(WS[2]), .WIDX_W(3)) dut_c (
    .clk2(clk2), .rst_n(rst_n), .inc(inc), .dec(dec), .clear(clear),
    .score(score_c), .sat(sat_c), .game_over(go_c), .winner(win_c), .tie(tie_c));

  initial clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  function automatic logic [7:0] toBcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 3; k++) begin
      m_score[k][0] = 0;
      m_score[k][1] = 0;
      m_go[k]  = 1'b0;
      m_win[k] = 0;
      m_tie[k] = 1'b0;
    end
    m_prev_inc = '0;
    m_prev_dec = '0;
  endtask

  // One clock edge of the game rules, applied to every instance.
  task automatic modelStep();
    bit up, dn;
    int hits;
    if (clear) begin
      modelReset();
      m_prev_inc = inc;
      m_prev_dec = dec;
      return;
    end
    for (int k = 0; k < 3; k++) begin
      if (!m_go[k]) begin
        for (int ch = 0; ch < 2; ch++) begin
          up = (EM[k] != 0) ? (inc[ch] && !m_prev_inc[ch]) : inc[ch];
          dn = (EM[k] != 0) ? (dec[ch] && !m_prev_dec[ch]) : dec[ch];
          if (up && !dn && m_score[k][ch] < 99) m_score[k][ch]++;
          else if (dn && !up && m_score[k][ch] > 0) m_score[k][ch]--;
        end
        if (WS[k] != 0) begin
          hits = 0;
          for (int ch = 0; ch < 2; ch++) begin
            if (m_score[k][ch] == WS[k]) begin
              if (hits == 0) m_win[k] = ch;
              hits++;
            end
          end
          if (hits > 0) begin
            m_go[k]  = 1'b1;
            m_tie[k] = (hits > 1);
          end
        end
      end
    end
    m_prev_inc = inc;
    m_prev_dec = dec;
  endtask

  task automatic checkOutput();
    logic [15:0] s;
    logic [1:0]  st;
    logic        g, t;
    logic [2:0]  w;
    string       n;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       begin s = score_a; st = sat_a; g = go_a; w = win_a; t = tie_a; n = "a"; end
        1:       begin s = score_b; st = sat_b; g = go_b; w = win_b; t = tie_b; n = "b"; end
        default: begin s = score_c; st = sat_c; g = go_c; w = win_c; t = tie_c; n = "c"; end
      endcase
      checkVal({n, ".score"}, s, {toBcd(m_score[k][1]), toBcd(m_score[k][0])});
      checkVal({n, ".sat"}, {14'd0, st},
               {14'd0, m_score[k][1] == 99, m_score[k][0] == 99});
      checkVal({n, ".game_over"}, {15'd0, g}, {15'd0, m_go[k]});
      checkVal({n, ".winner"}, {13'd0, w}, 16'(m_win[k]));
      checkVal({n, ".tie"}, {15'd0, t}, {15'd0, m_tie[k]});
    end
  endtask

  // Drive inputs after the check point, then take one edge and compare.
  task automatic applyStimulus(input logic [1:0] i, input logic [1:0] d, input logic c);
    inc   = i;
    dec   = d;
    clear = c;
    @(posedge clk2);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic pulse(input logic [1:0] i, input logic [1:0] d, input int n);
    repeat (n) begin
      applyStimulus(i, d, 1'b0);
      applyStimulus(2'b00, 2'b00, 1'b0);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    inc   = '0;
    dec   = '0;
    clear = 1'b0;
    modelReset();
    repeat (2) @(posedge clk2);
    #1;
    rst_n = 1'b1;
    checkOutput();

    // Asynchronous reset mid-cycle with inputs held high.
    pulse(2'b01, 2'b00, 3);
    applyStimulus(2'b11, 2'b00, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput();
    checkVal("async reset score", score_a, 16'h0000);
    inc = '0;
    @(posedge clk2);
    #1;
    rst_n = 1'b1;
    checkOutput();

    // Input held high through clear is not a new press.
    pulse(2'b01, 2'b00, 2);
    applyStimulus(2'b01, 2'b00, 1'b1);
    applyStimulus(2'b01, 2'b00, 1'b0);
    applyStimulus(2'b01, 2'b00, 1'b0);
    checkVal("held through clear", score_a, 16'h0000);
    applyStimulus(2'b00, 2'b00, 1'b0);
    applyStimulus(2'b01, 2'b00, 1'b0);
    checkVal("press after clear", score_a, 16'h0001);

    // Carry and saturation.
    applyStimulus(2'b00, 2'b00, 1'b1);
    pulse(2'b01, 2'b00, 9);
    checkVal("ch0 after 9", score_a, 16'h0009);
    pulse(2'b01, 2'b00, 1);
    checkVal("ch0 carry", score_a, 16'h0010);
    pulse(2'b01, 2'b00, 89);
    checkVal("ch0 at 99", score_a, 16'h0099);
    checkVal("sat at 99", {14'd0, sat_a}, 16'h0001);
    pulse(2'b01, 2'b00, 1);
    checkVal("ch0 saturated", score_a, 16'h0099);

    // Borrow and floor.
    applyStimulus(2'b00, 2'b00, 1'b1);
    pulse(2'b10, 2'b00, 10);
    checkVal("ch1 at 10", score_a, 16'h1000);
    pulse(2'b00, 2'b10, 1);
    checkVal("ch1 borrow", score_a, 16'h0900);
    pulse(2'b00, 2'b10, 10);
    checkVal("ch1 floor", score_a, 16'h0000);
    pulse(2'b00, 2'b10, 2);
    checkVal("ch1 floor held", score_a, 16'h0000);

    // Simultaneous events.
    applyStimulus(2'b00, 2'b00, 1'b1);
    pulse(2'b01, 2'b00, 42);
    pulse(2'b01, 2'b01, 1);
    checkVal("inc+dec cancel", score_a, 16'h0042);
    pulse(2'b11, 2'b00, 1);
    checkVal("both channels inc", score_a, 16'h0143);

    // Level mode counts every high cycle.
    applyStimulus(2'b00, 2'b00, 1'b1);
    repeat (5) applyStimulus(2'b01, 2'b00, 1'b0);
    applyStimulus(2'b00, 2'b00, 1'b0);
    checkVal("level mode 5", score_b, 16'h0005);
    checkVal("edge mode 1", score_a, 16'h0001);

    // Win on channel 1 and freeze.
    applyStimulus(2'b00, 2'b00, 1'b1);
    pulse(2'b10, 2'b00, 15);
    checkVal("win game_over", {15'd0, go_c}, 16'h0001);
    checkVal("win winner", {13'd0, win_c}, 16'h0001);
    checkVal("win tie", {15'd0, tie_c}, 16'h0000);
    pulse(2'b10, 2'b00, 2);
    pulse(2'b01, 2'b00, 2);
    checkVal("frozen scores", score_c, 16'h1500);
    applyStimulus(2'b00, 2'b00, 1'b1);
    checkVal("clear after win", score_c, 16'h0000);
    checkVal("clear game_over", {15'd0, go_c}, 16'h0000);

    // Tie when both channels reach the winning score together.
    pulse(2'b11, 2'b00, 14);
    pulse(2'b11, 2'b00, 1);
    checkVal("tie game_over", {15'd0, go_c}, 16'h0001);
    checkVal("tie winner", {13'd0, win_c}, 16'h0000);
    checkVal("tie flag", {15'd0, tie_c}, 16'h0001);
    checkVal("tie scores", score_c, 16'h1515);

    // Random traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      applyStimulus(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 31) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
